mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single word-wide instruction/data memory port between the instruction-fetch unit (IF) and the load/store unit (LS).
- Arbitrates between the two requesters round-robin and sequences each access through a 3-state FSM.
- Screens misaligned and out-of-range addresses before they reach memory and returns a per-requester response over valid/ready.
- Sits between the core pipeline and the memory instance; the memory's read is combinational and its write commits on posedge clock.

Parameters:
- MEM_BASE, 32'h0100_0000, byte address of the first memory location.
- MEM_SIZE, 4096, memory size in bytes; a multiple of 4.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- if_req_valid  in  1  fetch request present.
- if_req_ready  out  1  fetch request accepted this cycle.
- if_req_addr  in  32  fetch byte address.
- if_rsp_valid  out  1  fetch response present.
- if_rsp_ready  in  1  fetch consumer takes response.
- if_rsp_data  out  32  fetched word.
- if_rsp_err  out  1  fetch address misaligned or out of range.
- ls_req_valid  in  1  load/store request present.
- ls_req_ready  out  1  load/store request accepted this cycle.
- ls_req_addr  in  32  load/store byte address.
- ls_req_write  in  1  1 = store, 0 = load.
- ls_req_wdata  in  32  store data.
- ls_rsp_valid  out  1  load/store response present.
- ls_rsp_ready  in  1  consumer takes response.
- ls_rsp_data  out  32  load data; 0 for stores.
- ls_rsp_err  out  1  address misaligned or out of range.
- mem_address  out  32  memory address.
- mem_data_in  out  32  memory write data.
- mem_read_write  out  1  memory write strobe (1 = write).
- mem_data_out  in  32  memory combinational read data.
- busy  out  1  FSM not in IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset -> IDLE.
- Reset values: all *_rsp_valid 0; rsp data regs 0; err regs 0; mem_address 0; mem_data_in 0; mem_read_write 0; busy 0; last_grant = IF.
- IDLE arbitration:
  - Only IF valid -> grant IF. Only LS valid -> grant LS.
  - Both valid -> grant the requester that is not last_grant. After reset, LS wins the first tie.
  - The granted *_req_ready is asserted combinationally in IDLE only, while that requester's valid is high. Ungranted ready = 0.
- On accept (valid & ready), latch addr, write (forced 0 for IF), wdata and owner; update last_grant; go to ACCESS.
- Error flag is computed at accept:
  - err = (addr[1:0] != 0) | (addr < MEM_BASE) | (addr > MEM_BASE + MEM_SIZE - 4).
  - Use 33-bit arithmetic so the bounds cannot wrap.
- ACCESS state (exactly 1 cycle):
  - mem_address = latched addr; mem_data_in = latched wdata.
  - mem_read_write = write & !err & !reset.
  - At the closing edge, rsp_data <= (!write & !err) ? mem_data_out : 0.
  - Go to RESP.
- RESP state:
  - Owner's rsp_valid = 1, with rsp_data and rsp_err held stable. The other requester's rsp_valid = 0.
  - Hold until owner's rsp_ready = 1; at that edge go to IDLE.
- Latency: accept at cycle N, memory access at N+1, rsp_valid from N+2. Minimum 3 cycles per transaction; no request is accepted while busy.
- Outside ACCESS, mem_read_write = 0 and mem_address / mem_data_in hold their last latched values.
- Errored requests never strobe memory writes; they return data 0 with err = 1.
- Reset at any state: return to IDLE next edge and drop responses. Reset asserted during ACCESS of a store suppresses the write strobe, so no memory write commits.
- A requester may deassert valid before acceptance without effect; a request is considered only when valid is high in IDLE.

Test Plan:
- Fetch read: memory word at 0x0100_0000 = 0x0000_0013; if_req_addr = 0x0100_0000 -> if_rsp_valid at N+2, data 0x0000_0013, err 0; mem_read_write never 1.
- Store then load: LS store 0xDEAD_BEEF to 0x0100_0010 -> single-cycle mem_read_write pulse in ACCESS; then LS load of 0x0100_0010 -> ls_rsp_data 0xDEAD_BEEF.
- Simultaneous requests: both valid continuously from reset -> grant order LS, IF, LS, IF; each response goes to the correct port only.
- Errors: LS store to 0x0100_0002 -> ls_rsp_err 1, data 0, no write. IF fetch at 0x0000_0000 -> err 1. Fetch at MEM_BASE + MEM_SIZE - 4 -> err 0. Fetch at MEM_BASE + MEM_SIZE -> err 1.
- Backpressure: hold ls_rsp_ready = 0 for 5 cycles -> ls_rsp_valid and data stable, busy 1, if_req_ready 0 throughout; then release -> IDLE next cycle.
- Reset during a store's ACCESS cycle -> no memory write, FSM in IDLE, all rsp_valid 0 on the next cycle.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter that shares one word-wide memory port between instruction
// fetch and load/store, screening bad addresses and returning valid/ready responses.
module mem_port_arbiter #(
    parameter logic [31:0] MEM_BASE = 32'h0100_0000,
    parameter int unsigned MEM_SIZE = 4096
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  logic [31:0] if_req_addr,
    output logic        if_rsp_valid,
    input  logic        if_rsp_ready,
    output logic [31:0] if_rsp_data,
    output logic        if_rsp_err,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  logic [31:0] ls_req_addr,
    input  logic        ls_req_write,
    input  logic [31:0] ls_req_wdata,
    output logic        ls_rsp_valid,
    input  logic        ls_rsp_ready,
    output logic [31:0] ls_rsp_data,
    output logic        ls_rsp_err,
    output logic [31:0] mem_address,
    output logic [31:0] mem_data_in,
    output logic        mem_read_write,
    input  logic [31:0] mem_data_out,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam logic OWNER_IF = 1'b0;
    localparam logic OWNER_LS = 1'b1;

    // Widened to 33 bits so the upper bound cannot wrap near the top of the address space.
    function automatic logic addr_err(input logic [31:0] addr);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, MEM_BASE};
        hi = lo + 33'(MEM_SIZE) - 33'd4;
        return (addr[1:0] != 2'b00) || (a < lo) || (a > hi);
    endfunction

    state_t      state_r;
    state_t      next_state_s;
    logic        grant_if_s;
    logic        grant_ls_s;
    logic        last_grant_r;
    logic        owner_r;
    logic [31:0] addr_r;
    logic [31:0] wdata_r;
    logic        wr_r;
    logic        acc_err_r;
    logic [31:0] if_data_r;
    logic [31:0] ls_data_r;
    logic        if_err_r;
    logic        ls_err_r;
    logic [31:0] rd_data_s;

    // Next-state and grant logic; grants exist only in IDLE.
    always_comb begin
        next_state_s = state_r;
        grant_if_s   = 1'b0;
        grant_ls_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ls_req_valid && (!if_req_valid || (last_grant_r == OWNER_IF))) begin
                    grant_ls_s   = 1'b1;
                    next_state_s = ST_ACCESS;
                end else if (if_req_valid) begin
                    grant_if_s   = 1'b1;
                    next_state_s = ST_ACCESS;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_ACCESS: next_state_s = ST_RESP;
            ST_RESP: begin
                if ((owner_r == OWNER_LS) ? ls_rsp_ready : if_rsp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    assign rd_data_s = (!wr_r && !acc_err_r) ? mem_data_out : 32'd0;

    // Request latch at accept and response capture at the end of ACCESS.
    always_ff @(posedge clock) begin
        if (reset) begin
            last_grant_r <= OWNER_IF;
            owner_r      <= OWNER_IF;
            addr_r       <= 32'd0;
            wdata_r      <= 32'd0;
            wr_r         <= 1'b0;
            acc_err_r    <= 1'b0;
            if_data_r    <= 32'd0;
            ls_data_r    <= 32'd0;
            if_err_r     <= 1'b0;
            ls_err_r     <= 1'b0;
        end else begin
            if (grant_ls_s) begin
                addr_r       <= ls_req_addr;
                wdata_r      <= ls_req_wdata;
                wr_r         <= ls_req_write;
                acc_err_r    <= addr_err(ls_req_addr);
                owner_r      <= OWNER_LS;
                last_grant_r <= OWNER_LS;
            end else if (grant_if_s) begin
                addr_r       <= if_req_addr;
                wdata_r      <= 32'd0;
                wr_r         <= 1'b0;
                acc_err_r    <= addr_err(if_req_addr);
                owner_r      <= OWNER_IF;
                last_grant_r <= OWNER_IF;
            end
            if (state_r == ST_ACCESS) begin
                if (owner_r == OWNER_LS) begin
                    ls_data_r <= rd_data_s;
                    ls_err_r  <= acc_err_r;
                end else begin
                    if_data_r <= rd_data_s;
                    if_err_r  <= acc_err_r;
                end
            end
        end
    end

    assign if_req_ready   = grant_if_s;
    assign ls_req_ready   = grant_ls_s;
    assign if_rsp_valid   = (state_r == ST_RESP) && (owner_r == OWNER_IF);
    assign ls_rsp_valid   = (state_r == ST_RESP) && (owner_r == OWNER_LS);
    assign if_rsp_data    = if_data_r;
    assign ls_rsp_data    = ls_data_r;
    assign if_rsp_err     = if_err_r;
    assign ls_rsp_err     = ls_err_r;
    assign mem_address    = addr_r;
    assign mem_data_in    = wdata_r;
    // Reset gates the strobe so a store caught mid-ACCESS never commits.
    assign mem_read_write = (state_r == ST_ACCESS) && wr_r && !acc_err_r && !reset;
    assign busy           = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural memory behind the port.
module tb_mem_port_arbiter;

    logic        clock;
    logic        reset;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic [31:0] ls_req_addr;
    logic        ls_req_write;
    logic [31:0] ls_req_wdata;
    logic        ls_rsp_valid;
    logic        ls_rsp_ready;
    logic [31:0] ls_rsp_data;
    logic        ls_rsp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_data_in;
    logic        mem_read_write;
    logic [31:0] mem_data_out;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int write_cnt = 0;

    logic [31:0] mem_q [0:1023];
    logic [31:0] off_s;
    logic        in_range_s;

    mem_port_arbiter dut (
        .clock(clock), .reset(reset),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_addr(ls_req_addr),
        .ls_req_write(ls_req_write), .ls_req_wdata(ls_req_wdata),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_data(ls_rsp_data),
        .ls_rsp_err(ls_rsp_err),
        .mem_address(mem_address), .mem_data_in(mem_data_in), .mem_read_write(mem_read_write),
        .mem_data_out(mem_data_out), .busy(busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign off_s        = mem_address - 32'h0100_0000;
    assign in_range_s   = (off_s < 32'd4096);
    assign mem_data_out = in_range_s ? mem_q[off_s[11:2]] : 32'hA5A5_A5A5;

    always @(posedge clock) begin
        if (mem_read_write) begin
            write_cnt <= write_cnt + 1;
            if (in_range_s) mem_q[off_s[11:2]] <= mem_data_in;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete request on a single port with rsp_ready held high.
    task automatic do_req(input logic is_ls, input logic [31:0] addr, input logic wr,
                          input logic [31:0] wd, input logic [31:0] exp_data, input logic exp_err);
        int wc0;
        wc0 = write_cnt;
        if (is_ls) begin
            ls_req_valid = 1'b1; ls_req_addr = addr; ls_req_write = wr; ls_req_wdata = wd;
        end else begin
            if_req_valid = 1'b1; if_req_addr = addr;
        end
        #1;
        chk("req_ready", {31'd0, is_ls ? ls_req_ready : if_req_ready}, 32'd1);
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0; ls_req_write = 1'b0;
        chk("access_busy", {31'd0, busy}, 32'd1);
        chk("access_addr", mem_address, addr);
        chk("access_strobe", {31'd0, mem_read_write}, {31'd0, wr & ~exp_err});
        tick();
        chk("rsp_valid_owner", {31'd0, is_ls ? ls_rsp_valid : if_rsp_valid}, 32'd1);
        chk("rsp_valid_other", {31'd0, is_ls ? if_rsp_valid : ls_rsp_valid}, 32'd0);
        chk("rsp_data", is_ls ? ls_rsp_data : if_rsp_data, exp_data);
        chk("rsp_err", {31'd0, is_ls ? ls_rsp_err : if_rsp_err}, {31'd0, exp_err});
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("write_count", 32'(write_cnt - wc0), {31'd0, wr & ~exp_err});
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem_q[i] = 32'd0;
        mem_q[0]    = 32'h0000_0013;
        mem_q[1]    = 32'h1111_1111;
        mem_q[2]    = 32'h2222_2222;
        mem_q[1023] = 32'h7777_7777;
        reset = 1'b1;
        if_req_valid = 1'b0; if_req_addr = 32'd0; if_rsp_ready = 1'b1;
        ls_req_valid = 1'b0; ls_req_addr = 32'd0; ls_req_write = 1'b0; ls_req_wdata = 32'd0;
        ls_rsp_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_if_rsp_valid", {31'd0, if_rsp_valid}, 32'd0);
        chk("rst_ls_rsp_valid", {31'd0, ls_rsp_valid}, 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_data_in", mem_data_in, 32'd0);
        chk("rst_mem_rw", {31'd0, mem_read_write}, 32'd0);
        chk("rst_ls_rsp_data", ls_rsp_data, 32'd0);
        tick();

        do_req(1'b0, 32'h0100_0000, 1'b0, 32'd0, 32'h0000_0013, 1'b0);
        do_req(1'b1, 32'h0100_0010, 1'b1, 32'hDEAD_BEEF, 32'd0, 1'b0);
        chk("mem_stored", mem_q[4], 32'hDEAD_BEEF);
        do_req(1'b1, 32'h0100_0010, 1'b0, 32'd0, 32'hDEAD_BEEF, 1'b0);

        do_req(1'b1, 32'h0100_0002, 1'b1, 32'h1234_5678, 32'd0, 1'b1);
        do_req(1'b0, 32'h0000_0000, 1'b0, 32'd0, 32'd0, 1'b1);
        do_req(1'b0, 32'h0100_0FFC, 1'b0, 32'd0, 32'h7777_7777, 1'b0);
        do_req(1'b0, 32'h0100_1000, 1'b0, 32'd0, 32'd0, 1'b1);

        // Fresh reset so the first tie goes to LS, then alternate.
        reset = 1'b1; tick(); reset = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h0100_0004;
        ls_req_valid = 1'b1; ls_req_addr = 32'h0100_0008; ls_req_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("tie_ls_ready", {31'd0, ls_req_ready}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie_if_ready", {31'd0, if_req_ready}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick(); tick();
            chk("tie_ls_valid", {31'd0, ls_rsp_valid}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("tie_if_valid", {31'd0, if_rsp_valid}, (k % 2 == 0) ? 32'd0 : 32'd1);
            chk("tie_data", (k % 2 == 0) ? ls_rsp_data : if_rsp_data,
                (k % 2 == 0) ? 32'h2222_2222 : 32'h1111_1111);
            tick();
        end
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        tick();

        // Backpressure on the load/store response.
        ls_rsp_ready = 1'b0;
        ls_req_valid = 1'b1; ls_req_addr = 32'h0100_0010; ls_req_write = 1'b0;
        tick();
        ls_req_valid = 1'b0;
        if_req_valid = 1'b1; if_req_addr = 32'h0100_0000;
        tick();
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", {31'd0, ls_rsp_valid}, 32'd1);
            chk("bp_data", ls_rsp_data, 32'hDEAD_BEEF);
            chk("bp_busy", {31'd0, busy}, 32'd1);
            chk("bp_if_ready", {31'd0, if_req_ready}, 32'd0);
            tick();
        end
        if_req_valid = 1'b0;
        ls_rsp_ready = 1'b1;
        tick();
        chk("bp_release_busy", {31'd0, busy}, 32'd0);
        chk("bp_release_valid", {31'd0, ls_rsp_valid}, 32'd0);

        // Reset landing on a store's ACCESS cycle.
        begin
            int wc0;
            wc0 = write_cnt;
            ls_req_valid = 1'b1; ls_req_addr = 32'h0100_0020; ls_req_write = 1'b1;
            ls_req_wdata = 32'hCAFE_F00D;
            tick();
            ls_req_valid = 1'b0; ls_req_write = 1'b0;
            chk("rstacc_strobe_pre", {31'd0, mem_read_write}, 32'd1);
            reset = 1'b1;
            #1;
            chk("rstacc_strobe_gated", {31'd0, mem_read_write}, 32'd0);
            tick();
            reset = 1'b0;
            chk("rstacc_busy", {31'd0, busy}, 32'd0);
            chk("rstacc_ls_valid", {31'd0, ls_rsp_valid}, 32'd0);
            chk("rstacc_if_valid", {31'd0, if_rsp_valid}, 32'd0);
            chk("rstacc_writes", 32'(write_cnt - wc0), 32'd0);
            chk("rstacc_mem", mem_q[8], 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
